// File: rtl/spi_boot_sequencer.sv
// Boot-time SPI sequencer: pulls calibration bytes from EEPROM, programs gain/trigger DACs,
// then hands the SPI master to the command dispatcher through a registered pass-through.
package spi_boot_pkg;
  typedef enum logic [2:0] {
    SS_NONE    = 3'd0,
    SS_EEPROM  = 3'd1,
    SS_CH1     = 3'd2,
    SS_CH2     = 3'd3,
    SS_CH3     = 3'd4,
    SS_TRIGGER = 3'd5
  } SlaveSelect;

  typedef struct packed {
    SlaveSelect  ss;
    logic [15:0] data;
  } spi_req_t;
endpackage

module spi_boot_sequencer
  import spi_boot_pkg::*;
#(
  parameter logic [5:0] EEP_BASE = 6'h00,
  parameter bit         BOOT_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        wrt_SPI,
  output logic [15:0] SPI_data,
  output SlaveSelect  ss,
  input  logic        SPI_done,
  input  logic [7:0]  EEP_data,
  input  logic        c_wrt_SPI,
  input  logic [15:0] c_SPI_data,
  input  SlaveSelect  c_ss,
  output logic        c_SPI_done,
  output logic [7:0]  c_EEP_data,
  output logic        c_busy,
  output logic        boot_done,
  output logic        req_ovr,
  output logic [8:0]  cal_gain,
  output logic [7:0]  cal_trig
);

  typedef enum logic [2:0] {
    B_START, B_RD_ADDR, B_RD_DATA, B_WR_GAIN, B_WR_TRIG, RUN_IDLE, RUN_BUSY
  } state_t;

  state_t          state;
  logic [1:0]      idx;
  logic [1:0]      idx_inc;
  logic [3:0][7:0] cal;
  logic            tx_act;
  logic            done_ok;
  logic            pend_vld;
  spi_req_t        pend;
  spi_req_t        c_req;

  function automatic logic [15:0] addr_frame(input logic [1:0] i);
    logic [5:0] a;
    a = EEP_BASE + {4'b0000, i};
    return {2'b00, a, 8'h00};
  endfunction

  function automatic logic [15:0] gain_frame(input logic [2:0] code);
    case (code)
      3'd0:    return 16'h1302;
      3'd1:    return 16'h1305;
      3'd2:    return 16'h1309;
      3'd3:    return 16'h1314;
      3'd4:    return 16'h1328;
      3'd5:    return 16'h1346;
      3'd6:    return 16'h136B;
      default: return 16'h13DD;
    endcase
  endfunction

  function automatic SlaveSelect ch_ss(input logic [1:0] i);
    case (i)
      2'd0:    return SS_CH1;
      2'd1:    return SS_CH2;
      default: return SS_CH3;
    endcase
  endfunction

  assign idx_inc = idx + 2'd1;
  // A done pulse only counts when we actually have a transaction in flight.
  assign done_ok = SPI_done & tx_act;
  assign c_req   = '{ss: c_ss, data: c_SPI_data};

  assign c_SPI_done = done_ok & (state == RUN_BUSY);
  assign c_EEP_data = EEP_data;
  assign c_busy     = ~boot_done | pend_vld | (state == RUN_BUSY);
  assign cal_gain   = {cal[2][2:0], cal[1][2:0], cal[0][2:0]};
  assign cal_trig   = cal[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= B_START;
      idx       <= 2'd0;
      cal       <= '0;
      tx_act    <= 1'b0;
      wrt_SPI   <= 1'b0;
      SPI_data  <= 16'h0000;
      ss        <= SS_NONE;
      boot_done <= 1'b0;
      req_ovr   <= 1'b0;
      pend_vld  <= 1'b0;
      pend      <= '0;
    end else begin
      wrt_SPI <= 1'b0;
      // Release the slave after completion; a chained step below overrides this.
      if (done_ok) begin
        tx_act <= 1'b0;
        ss     <= SS_NONE;
      end

      case (state)
        B_START: begin
          if (BOOT_EN) begin
            idx      <= 2'd0;
            wrt_SPI  <= 1'b1;
            tx_act   <= 1'b1;
            SPI_data <= addr_frame(2'd0);
            ss       <= SS_EEPROM;
            state    <= B_RD_ADDR;
          end else begin
            boot_done <= 1'b1;
            state     <= RUN_IDLE;
          end
        end
        B_RD_ADDR: begin
          if (done_ok) begin
            wrt_SPI  <= 1'b1;
            tx_act   <= 1'b1;
            SPI_data <= 16'h0000;
            ss       <= SS_EEPROM;
            state    <= B_RD_DATA;
          end
        end
        B_RD_DATA: begin
          if (done_ok) begin
            cal[idx] <= EEP_data;
            wrt_SPI  <= 1'b1;
            tx_act   <= 1'b1;
            if (idx != 2'd3) begin
              idx      <= idx_inc;
              SPI_data <= addr_frame(idx_inc);
              ss       <= SS_EEPROM;
              state    <= B_RD_ADDR;
            end else begin
              idx      <= 2'd0;
              SPI_data <= gain_frame(cal[0][2:0]);
              ss       <= SS_CH1;
              state    <= B_WR_GAIN;
            end
          end
        end
        B_WR_GAIN: begin
          if (done_ok) begin
            wrt_SPI <= 1'b1;
            tx_act  <= 1'b1;
            if (idx < 2'd2) begin
              idx      <= idx_inc;
              SPI_data <= gain_frame(cal[idx_inc][2:0]);
              ss       <= ch_ss(idx_inc);
            end else begin
              SPI_data <= {8'h13, cal[3]};
              ss       <= SS_TRIGGER;
              state    <= B_WR_TRIG;
            end
          end
        end
        B_WR_TRIG: begin
          if (done_ok) begin
            boot_done <= 1'b1;
            state     <= RUN_IDLE;
          end
        end
        RUN_IDLE: begin
          if (pend_vld) begin
            wrt_SPI  <= 1'b1;
            tx_act   <= 1'b1;
            SPI_data <= pend.data;
            ss       <= pend.ss;
            state    <= RUN_BUSY;
          end else if (c_wrt_SPI) begin
            wrt_SPI  <= 1'b1;
            tx_act   <= 1'b1;
            SPI_data <= c_SPI_data;
            ss       <= c_ss;
            state    <= RUN_BUSY;
          end
        end
        RUN_BUSY: begin
          if (done_ok) state <= RUN_IDLE;
        end
        default: state <= B_START;
      endcase

      // One-entry pending buffer. In RUN_IDLE the held entry drains this cycle,
      // so a fresh request can take its slot.
      if (c_wrt_SPI) begin
        if (state == RUN_IDLE) begin
          if (pend_vld) pend <= c_req;
        end else if (state == RUN_BUSY && !done_ok) begin
          req_ovr <= 1'b1;
        end else if (pend_vld) begin
          req_ovr <= 1'b1;
        end else begin
          pend_vld <= 1'b1;
          pend     <= c_req;
        end
      end else if (state == RUN_IDLE && pend_vld) begin
        pend_vld <= 1'b0;
      end
    end
  end

endmodule
